mask_apply_stream: RTL and testbench

Downstream consumer of the 8-entry byte mask table (type mask_t, an unpacked array of 8 bytes indexed [7:0]). It receives a byte stream over a valid/ready handshake. Byte k of each frame is ANDed with mask entry MASK[k mod 8], and the result is emitted through a registered valid/ready output stage. Short frames are flagged, and the mask index is tracked per frame.

---
 rtl/mask_apply_stream.sv | 143 ++++++++++++++
 tb/tb_mask_apply_stream.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_apply_stream.sv
// Byte-stream masker: byte k of a frame is ANDed with MASK[k mod 8] into a single registered output stage.
// Build option MASK_CHECKSUM_EN appends one XOR-checksum beat after every frame.
module mask_apply_stream #(
  parameter logic [7:0] MASK [7:0] = '{8'hE1, 8'h03, 8'h07, 8'h3F, 8'h33, 8'hC3, 8'hC3, 8'h37},
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             frame_err
);

  // Handshake: a byte transfers on in_valid && in_ready, a beat on out_valid && out_ready.
  // The output register may be reloaded in the same cycle it is drained, and out_* hold
  // stable while out_valid && !out_ready.

`ifdef MASK_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, CSUM = 2'd2} state_t;
  localparam state_t FRAME_DONE = CSUM;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
  localparam state_t FRAME_DONE = IDLE;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             consume;
  logic             frame_end;
  logic [7:0]       masked;

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign frame_end = accept && in_last;
  assign masked    = in_data & MASK[idx];

`ifdef MASK_CHECKSUM_EN
  logic [7:0] acc;
  logic       csum_loaded;
  logic       load_csum;

  // The checksum beat enters the output register once the final data beat has left it.
  assign load_csum = (state_q == CSUM) && !csum_loaded && (!out_valid || out_ready);
  assign in_ready  = (!out_valid || out_ready) && (state_q != CSUM);
`else
  assign in_ready  = !out_valid || out_ready;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BUSY: begin
        if (frame_end) begin
          state_d = FRAME_DONE;
        end else if (accept) begin
          state_d = BUSY;
        end
      end
`ifdef MASK_CHECKSUM_EN
      CSUM: begin
        if (csum_loaded && consume) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_idx   <= '0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_end && (idx != '1);
      if (frame_end) begin
        idx <= '0;
      end else if (accept) begin
        idx <= idx + IDX_W'(1);
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= masked;
        out_idx   <= idx;
`ifdef MASK_CHECKSUM_EN
        out_last  <= 1'b0;
      end else if (load_csum) begin
        out_valid <= 1'b1;
        out_data  <= acc;
        out_idx   <= '0;
        out_last  <= 1'b1;
`else
        out_last  <= in_last;
`endif
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MASK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 8'h00;
      csum_loaded <= 1'b0;
    end else begin
      if (load_csum) begin
        acc <= 8'h00;
      end else if (accept) begin
        acc <= acc ^ masked;
      end
      // Cleared on the first non-CSUM cycle, which always precedes the next frame end.
      if (load_csum) begin
        csum_loaded <= 1'b1;
      end else if (state_q != CSUM) begin
        csum_loaded <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mask_apply_stream.sv
// Self-checking bench for mask_apply_stream: directed frames plus a randomized run,
// compared against a frame-level mask/checksum model.
module tb_mask_apply_stream;

  localparam logic [7:0] MASK_TB [8] = '{8'h37, 8'hC3, 8'hC3, 8'h33, 8'h3F, 8'h07, 8'h03, 8'hE1};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_last;
  logic       frame_err;

  int checks  = 0;
  int fails   = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int cyc     = 0;
  bit tx_done;

  logic [11:0] exp_q[$];
  logic [11:0] act_q[$];
  int          stamp_q[$];
  logic [7:0]  frm_q[$];

  mask_apply_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // monitor: a beat seen valid&&ready at negedge is consumed at the next posedge
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        act_q.push_back({out_data, out_idx, out_last});
        stamp_q.push_back(cyc);
      end
      if (frame_err === 1'b1) err_cnt++;
    end
  end

  // reference model: byte k -> byte & MASK[k mod 8]; frame_err when length is not a multiple of 8
  task automatic model_frame();
    logic [7:0] m;
    logic [7:0] cs;
    cs = 8'h00;
    for (int k = 0; k < frm_q.size(); k++) begin
      m  = frm_q[k] & MASK_TB[k % 8];
      cs = cs ^ m;
`ifdef MASK_CHECKSUM_EN
      exp_q.push_back({m, 3'(k % 8), 1'b0});
`else
      exp_q.push_back({m, 3'(k % 8), (k == frm_q.size() - 1)});
`endif
    end
`ifdef MASK_CHECKSUM_EN
    exp_q.push_back({cs, 3'd0, 1'b1});
`endif
    if (frm_q.size() % 8 != 0) exp_err++;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    stamp_q.delete();
    err_cnt = 0;
    exp_err = 0;
  endtask

  // driver tasks: called at posedge+1, return at posedge+1 after acceptance
  task automatic drive_byte(input logic [7:0] d, input logic l);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (in_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL drive_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int k = 0; k < frm_q.size(); k++) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_byte(frm_q[k], (k == frm_q.size() - 1));
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (act_q.size() < exp_q.size() && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data got %h required 00", out_data); end
    checks++; if (out_idx !== 3'd0) begin fails++; $display("FAIL rst_out_idx got %0d required 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b required 0", out_last); end
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rst_frame_err got %b required 0", frame_err); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    int n;
    clear_sb();
    out_ready = 1'b1;
    frm_q.delete();
    repeat (8) frm_q.push_back(8'hFF);
    model_frame();
    send_frame(0);
    wait_drain();
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL full_count got %0d required %0d", act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL full_beat%0d got %h required %h", i, act_q[i], exp_q[i]); end
    end
    for (int i = 1; i < stamp_q.size(); i++) begin
      checks++;
      if (stamp_q[i] != stamp_q[i-1] + 1) begin fails++; $display("FAIL full_bubble beat%0d cycle %0d required %0d", i, stamp_q[i], stamp_q[i-1] + 1); end
    end
    checks++; if (err_cnt != exp_err) begin fails++; $display("FAIL full_frame_err got %0d required %0d", err_cnt, exp_err); end
  endtask

  task automatic test_backpressure();
    int n;
    int g;
    clear_sb();
    out_ready = 1'b1;
    frm_q.delete();
    repeat (8) frm_q.push_back(8'hFF);
    model_frame();
    fork
      send_frame(0);
      begin
        g = 0;
        do begin
          @(posedge clk);
          #1;
          g++;
        end while (!(out_valid === 1'b1 && out_idx === 3'd2) && g < 100);
        if (g >= 100) begin checks++; fails++; $display("FAIL bp_timeout out_idx=%0d required 2", out_idx); end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++; if (out_data !== 8'hC3) begin fails++; $display("FAIL bp_hold_data got %h required c3", out_data); end
          checks++; if (out_idx !== 3'd2) begin fails++; $display("FAIL bp_hold_idx got %0d required 2", out_idx); end
          checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid got %b required 1", out_valid); end
          checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b required 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count got %0d required %0d", act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat%0d got %h required %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_odd_frame(input int len, input logic [7:0] val);
    int n;
    clear_sb();
    out_ready = 1'b1;
    frm_q.delete();
    repeat (len) frm_q.push_back(val);
    model_frame();
    send_frame(0);
    checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL len%0d_err_pulse got %b required 1", len, frame_err); end
    @(posedge clk);
    #1;
    checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL len%0d_err_width got %b required 0", len, frame_err); end
    wait_drain();
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL len%0d_count got %0d required %0d", len, act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL len%0d_beat%0d got %h required %h", len, i, act_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt != exp_err) begin fails++; $display("FAIL len%0d_err_count got %0d required %0d", len, err_cnt, exp_err); end
  endtask

  task automatic test_short_frame();
    test_odd_frame(3, 8'hAA);
  endtask

  task automatic test_long_frame();
    test_odd_frame(10, 8'hFF);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    clear_sb();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive_byte(8'hFF, 1'b0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid got %b required 1", out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b required 0", out_valid); end
    checks++; if (out_idx !== 3'd0) begin fails++; $display("FAIL midrst_idx got %0d required 0", out_idx); end
    rst = 1'b0;
    clear_sb();
    frm_q.delete();
    frm_q.push_back(8'hFF);
    model_frame();
    send_frame(0);
    wait_drain();
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL midrst_count got %0d required %0d", act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL midrst_beat%0d got %h required %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int n;
    int sent;
    int len;
    clear_sb();
    sent = 0;
    tx_done = 1'b0;
    fork
      begin
        while (sent < 1000) begin
          len = $urandom_range(1, 20);
          if (len > 1000 - sent) len = 1000 - sent;
          frm_q.delete();
          for (int k = 0; k < len; k++) frm_q.push_back(8'($urandom));
          model_frame();
          send_frame(2);
          sent += len;
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++; if (act_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got %0d required %0d", act_q.size(), exp_q.size()); end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_beat%0d got %h required %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (err_cnt != exp_err) begin fails++; $display("FAIL rand_frame_err got %0d required %0d", err_cnt, exp_err); end
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
